// File: rtl/dr_adder_sequencer.sv
`timescale 1ns/1ps
// dr_adder_sequencer
//
// Clocked controller for a dual-rail ripple adder built from full_adder_tgl
// cells. Binary operands taken from a synchronous valid/ready stream are
// encoded onto rail pairs. Completion is detected on the synchronised adder
// outputs, and the decoded result is returned on a second valid/ready stream.
// In four-phase mode the return-to-spacer phase is sequenced before the
// result is presented. The block also owns the adder reset and a per-phase
// timeout watchdog.
//
// Parameters:
//   ENC     "TP" two-phase toggle, "FP" four-phase return-to-zero
//   WIDTH   operand width in bits (>= 1)
//   TIMEOUT cycle limit per wait phase (1..65535)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand stream; in_a, in_b, in_cin operands
//   out_valid/out_ready   result stream; out_sum, out_cout, out_err
//   dp_rst                active-high reset to the adder chain
//   dr_a, dr_b, dr_cin    operand rail pairs ([1] true rail, [0] false rail)
//   dr_s, dr_cout         asynchronous result rail pairs from the adder
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its payload while valid is high and
// ready is low, and ready never depends combinationally on valid.
//
// Optional feature: DR_SEQ_RESULT_CHECK_EN adds a binary reference sum
// compared against the decoded result. A mismatch raises out_err and bumps
// the saturating internal counter chk_fail_cnt.
module dr_adder_sequencer #(
  parameter ENC = "TP",
  parameter int WIDTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               out_err,
  output logic               dp_rst,
  output logic [2*WIDTH-1:0] dr_a,
  output logic [2*WIDTH-1:0] dr_b,
  output logic [1:0]         dr_cin,
  input  logic [2*WIDTH-1:0] dr_s,
  input  logic [1:0]         dr_cout
);

  // Result pairs: WIDTH sum pairs plus the carry-out pair on top.
  localparam int          NP       = WIDTH + 1;
  localparam int          RW       = 2 * NP;
  localparam bit          IS_FP    = (ENC == "FP");
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  generate
    if (ENC != "TP" && ENC != "FP") begin : g_bad_enc
      $error("dr_adder_sequencer: ENC must be TP or FP");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_RTZ   = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rst_cnt_q;
  logic [RW-1:0]      sync1_q, sync2_q;
  logic [RW-1:0]      ref_q, ref_d;
  logic [2*WIDTH-1:0] dr_a_q, dr_a_d, dr_b_q, dr_b_d;
  logic [1:0]         dr_cin_q, dr_cin_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               filt_q, filt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               err_q, err_d;
  logic               go_err;

  logic [RW-1:0]      diff;
  logic [NP-1:0]      dec;
  logic               comp_data;
  logic               comp_spacer;

`ifdef DR_SEQ_RESULT_CHECK_EN
  logic [WIDTH:0]     exp_q, exp_d;
  logic [15:0]        chk_fail_cnt, chk_fail_cnt_d;
`endif

  // FP places v on rail[v] from spacer; TP toggles rail[v] of the current
  // level. Both reduce to XOR with the one-hot {v, ~v}.
  function automatic logic [1:0] enc_pair(input logic [1:0] cur, input logic v);
    return IS_FP ? {v, ~v} : (cur ^ {v, ~v});
  endfunction

  // dp_rst is held through the first two edges after release; the block
  // offers in_ready one edge after that so the adder sees a clean spacer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q <= 2'd0;
    end else if (rst_cnt_q != 2'd3) begin
      rst_cnt_q <= rst_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {dr_cout, dr_s};
      sync2_q <= sync1_q;
    end
  end

  // In TP a rail that changed since the last completion marks the value, so
  // both completion and decode work on the difference to the reference.
  always_comb begin
    diff      = IS_FP ? sync2_q : (sync2_q ^ ref_q);
    comp_data = 1'b1;
    dec       = '0;
    for (int i = 0; i < NP; i++) begin
      if (!(^diff[2*i +: 2])) comp_data = 1'b0;
      dec[i] = diff[2*i+1];
    end
    comp_spacer = (sync2_q == '0);
  end

  always_comb begin
    state_d  = state_q;
    dr_a_d   = dr_a_q;
    dr_b_d   = dr_b_q;
    dr_cin_d = dr_cin_q;
    ref_d    = ref_q;
    tmo_d    = tmo_q;
    filt_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = err_q;
    go_err   = 1'b0;
`ifdef DR_SEQ_RESULT_CHECK_EN
    exp_d          = exp_q;
    chk_fail_cnt_d = chk_fail_cnt;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < WIDTH; i++) begin
            dr_a_d[2*i +: 2] = enc_pair(dr_a_q[2*i +: 2], in_a[i]);
            dr_b_d[2*i +: 2] = enc_pair(dr_b_q[2*i +: 2], in_b[i]);
          end
          dr_cin_d = enc_pair(dr_cin_q, in_cin);
          tmo_d    = '0;
          state_d  = S_DRIVE;
`ifdef DR_SEQ_RESULT_CHECK_EN
          exp_d = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
`endif
        end
      end
      S_DRIVE: begin
        // Completion wins over a timeout landing on the same edge.
        if (comp_data && filt_q) begin
          sum_d  = dec[WIDTH-1:0];
          cout_d = dec[WIDTH];
`ifdef DR_SEQ_RESULT_CHECK_EN
          err_d = (dec != exp_q);
          if (dec != exp_q && chk_fail_cnt != 16'hFFFF) begin
            chk_fail_cnt_d = chk_fail_cnt + 16'd1;
          end
`else
          err_d = 1'b0;
`endif
          if (IS_FP) begin
            dr_a_d   = '0;
            dr_b_d   = '0;
            dr_cin_d = '0;
            tmo_d    = '0;
            state_d  = S_RTZ;
          end else begin
            ref_d   = sync2_q;
            state_d = S_HOLD;
          end
        end else if (tmo_q == TMO_LAST) begin
          go_err = 1'b1;
        end else begin
          tmo_d  = tmo_q + 16'd1;
          filt_d = comp_data;
        end
      end
      S_RTZ: begin
        if (comp_spacer && filt_q) begin
          state_d = S_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          go_err = 1'b1;
        end else begin
          tmo_d  = tmo_q + 16'd1;
          filt_d = comp_spacer;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      S_ERR: begin
        // Track whatever the chain finally settles to so the next TP
        // operation starts from the real rail levels.
        if (!IS_FP) ref_d = sync2_q;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_err) begin
      state_d = S_ERR;
      sum_d   = '0;
      cout_d  = 1'b0;
      err_d   = 1'b1;
      if (IS_FP) begin
        dr_a_d   = '0;
        dr_b_d   = '0;
        dr_cin_d = '0;
      end else begin
        ref_d = sync2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dr_a_q   <= '0;
      dr_b_q   <= '0;
      dr_cin_q <= '0;
      ref_q    <= '0;
      tmo_q    <= '0;
      filt_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dr_a_q   <= dr_a_d;
      dr_b_q   <= dr_b_d;
      dr_cin_q <= dr_cin_d;
      ref_q    <= ref_d;
      tmo_q    <= tmo_d;
      filt_q   <= filt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

`ifdef DR_SEQ_RESULT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q        <= '0;
      chk_fail_cnt <= '0;
    end else begin
      exp_q        <= exp_d;
      chk_fail_cnt <= chk_fail_cnt_d;
    end
  end
`endif

  assign in_ready  = (state_q == S_IDLE) && (rst_cnt_q == 2'd3);
  assign dp_rst    = ~rst_cnt_q[1];
  assign out_valid = (state_q == S_HOLD) || (state_q == S_ERR);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_err   = err_q;
  assign dr_a      = dr_a_q;
  assign dr_b      = dr_b_q;
  assign dr_cin    = dr_cin_q;

endmodule

// File: tb/tb_dr_adder_sequencer.sv
`timescale 1ns/1ps
module tb_dr_adder_sequencer;

  localparam logic [1:0] SEL_TP1 = 2'd0;
  localparam logic [1:0] SEL_TP4 = 2'd1;
  localparam logic [1:0] SEL_FP4 = 2'd2;

  // ---------------- clock / reset / shared drive ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] sel;
  logic       valid_drv;
  logic       out_ready;
  logic [3:0] a_drv, b_drv;
  logic       cin_drv;
  logic       cout_kill;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- TP, WIDTH=1 ----------------
  logic       t1_in_ready, t1_out_valid, t1_out_cout, t1_out_err, t1_dp_rst;
  logic [0:0] t1_out_sum;
  logic [1:0] t1_dr_a, t1_dr_b, t1_dr_cin;
  logic [9:0] t1_mo = '0;
  logic [1:0] t1_pa = '0, t1_pb = '0, t1_pc = '0;

  dr_adder_sequencer #(.ENC("TP"), .WIDTH(1), .TIMEOUT(16)) u_tp1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(valid_drv && sel == SEL_TP1), .in_ready(t1_in_ready),
    .in_a(a_drv[0:0]), .in_b(b_drv[0:0]), .in_cin(cin_drv),
    .out_valid(t1_out_valid), .out_ready(out_ready),
    .out_sum(t1_out_sum), .out_cout(t1_out_cout), .out_err(t1_out_err),
    .dp_rst(t1_dp_rst), .dr_a(t1_dr_a), .dr_b(t1_dr_b), .dr_cin(t1_dr_cin),
    .dr_s(t1_mo[1:0]), .dr_cout(t1_mo[3:2])
  );

  // ---------------- TP, WIDTH=4 ----------------
  logic       t4_in_ready, t4_out_valid, t4_out_cout, t4_out_err, t4_dp_rst;
  logic [3:0] t4_out_sum;
  logic [7:0] t4_dr_a, t4_dr_b;
  logic [1:0] t4_dr_cin;
  logic [9:0] t4_mo = '0;
  logic [7:0] t4_pa = '0, t4_pb = '0;
  logic [1:0] t4_pc = '0;

  dr_adder_sequencer #(.ENC("TP"), .WIDTH(4), .TIMEOUT(16)) u_tp4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(valid_drv && sel == SEL_TP4), .in_ready(t4_in_ready),
    .in_a(a_drv), .in_b(b_drv), .in_cin(cin_drv),
    .out_valid(t4_out_valid), .out_ready(out_ready),
    .out_sum(t4_out_sum), .out_cout(t4_out_cout), .out_err(t4_out_err),
    .dp_rst(t4_dp_rst), .dr_a(t4_dr_a), .dr_b(t4_dr_b), .dr_cin(t4_dr_cin),
    .dr_s(t4_mo[7:0]), .dr_cout(t4_mo[9:8])
  );

  // ---------------- FP, WIDTH=4 ----------------
  logic       f4_in_ready, f4_out_valid, f4_out_cout, f4_out_err, f4_dp_rst;
  logic [3:0] f4_out_sum;
  logic [7:0] f4_dr_a, f4_dr_b;
  logic [1:0] f4_dr_cin;
  logic [9:0] f4_mo;

  dr_adder_sequencer #(.ENC("FP"), .WIDTH(4), .TIMEOUT(16)) u_fp4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(valid_drv && sel == SEL_FP4), .in_ready(f4_in_ready),
    .in_a(a_drv), .in_b(b_drv), .in_cin(cin_drv),
    .out_valid(f4_out_valid), .out_ready(out_ready),
    .out_sum(f4_out_sum), .out_cout(f4_out_cout), .out_err(f4_out_err),
    .dp_rst(f4_dp_rst), .dr_a(f4_dr_a), .dr_b(f4_dr_b), .dr_cin(f4_dr_cin),
    .dr_s(f4_mo[7:0]), .dr_cout(f4_mo[9:8] & {2{~cout_kill}})
  );

  // ---------------- zero-delay dual-rail adder model ----------------
  // a_r/b_r/c_r are rail levels (FP) or rail changes since the last
  // evaluation (TP). Result pair i < w is sum bit i, pair w is carry out.
  function automatic logic [9:0] dr_eval(input logic [7:0] a_r, input logic [7:0] b_r,
                                         input logic [1:0] c_r, input int w, input bit fp,
                                         input logic [9:0] prev, output bit ok);
    logic [9:0]  r;
    logic [31:0] sv;
    int          av, bv;
    logic        sb;
    ok = ^c_r;
    av = 0;
    bv = 0;
    for (int i = 0; i < w; i++) begin
      if (!(^a_r[2*i +: 2]) || !(^b_r[2*i +: 2])) ok = 1'b0;
      if (a_r[2*i+1]) av += (1 << i);
      if (b_r[2*i+1]) bv += (1 << i);
    end
    sv = 32'(av + bv + int'(c_r[1]));
    r  = fp ? 10'd0 : prev;
    if (ok) begin
      for (int i = 0; i <= w; i++) begin
        sb = sv[i];
        r[2*i +: 2] = fp ? {sb, ~sb} : (prev[2*i +: 2] ^ {sb, ~sb});
      end
    end
    return r;
  endfunction

  always @(t1_dr_a, t1_dr_b, t1_dr_cin, t1_dp_rst) begin : tp1_model
    logic [9:0] nx;
    bit         ok;
    if (t1_dp_rst) begin
      t1_pa = '0; t1_pb = '0; t1_pc = '0; t1_mo = '0;
    end else begin
      nx = dr_eval({6'b0, t1_dr_a ^ t1_pa}, {6'b0, t1_dr_b ^ t1_pb}, t1_dr_cin ^ t1_pc,
                   1, 1'b0, t1_mo, ok);
      if (ok) begin
        t1_mo = nx; t1_pa = t1_dr_a; t1_pb = t1_dr_b; t1_pc = t1_dr_cin;
      end
    end
  end

  always @(t4_dr_a, t4_dr_b, t4_dr_cin, t4_dp_rst) begin : tp4_model
    logic [9:0] nx;
    bit         ok;
    if (t4_dp_rst) begin
      t4_pa = '0; t4_pb = '0; t4_pc = '0; t4_mo = '0;
    end else begin
      nx = dr_eval(t4_dr_a ^ t4_pa, t4_dr_b ^ t4_pb, t4_dr_cin ^ t4_pc, 4, 1'b0, t4_mo, ok);
      if (ok) begin
        t4_mo = nx; t4_pa = t4_dr_a; t4_pb = t4_dr_b; t4_pc = t4_dr_cin;
      end
    end
  end

  always_comb begin : fp4_model
    bit ok;
    f4_mo = dr_eval(f4_dr_a, f4_dr_b, f4_dr_cin, 4, 1'b1, 10'd0, ok);
    if (f4_dp_rst) f4_mo = '0;
  end

  // ---------------- view of the selected instance ----------------
  logic       cur_in_ready, cur_out_valid, cur_cout, cur_err;
  logic [3:0] cur_sum;
  always_comb begin
    cur_in_ready  = f4_in_ready;
    cur_out_valid = f4_out_valid;
    cur_sum       = f4_out_sum;
    cur_cout      = f4_out_cout;
    cur_err       = f4_out_err;
    case (sel)
      SEL_TP1: begin
        cur_in_ready = t1_in_ready; cur_out_valid = t1_out_valid;
        cur_sum = {3'b0, t1_out_sum}; cur_cout = t1_out_cout; cur_err = t1_out_err;
      end
      SEL_TP4: begin
        cur_in_ready = t4_in_ready; cur_out_valid = t4_out_valid;
        cur_sum = t4_out_sum; cur_cout = t4_out_cout; cur_err = t4_out_err;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic accept_only(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                             input logic cin);
    bit rdy, seen;
    sel = s; a_drv = a; b_drv = b; cin_drv = cin; valid_drv = 1'b1;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      rdy = cur_in_ready;
      @(posedge clk); #1;
      if (rdy) seen = 1'b1;
    end
    valid_drv = 1'b0;
    check("accept", 32'(seen), 32'd1);
  endtask

  task automatic do_op(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, output int lat);
    accept_only(s, a, b, cin);
    lat = 0;
    while (!cur_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int lat;
    int bad;
    vecs[0] = '{SEL_TP1, 4'h1, 4'h1, 1'b1, 4'h1, 1'b1, 4};
    vecs[1] = '{SEL_TP1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4};
    vecs[2] = '{SEL_TP1, 4'h0, 4'h1, 1'b1, 4'h0, 1'b1, 4};
    vecs[3] = '{SEL_FP4, 4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 8};
    vecs[4] = '{SEL_FP4, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 8};
    vecs[5] = '{SEL_FP4, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8};
    vecs[6] = '{SEL_TP4, 4'h7, 4'h9, 1'b0, 4'h0, 1'b1, 4};
    vecs[7] = '{SEL_TP4, 4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 4};
    vecs[8] = '{SEL_TP4, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 4};

    rst_n = 1'b0; sel = SEL_FP4; valid_drv = 1'b0; out_ready = 1'b0;
    a_drv = '0; b_drv = '0; cin_drv = 1'b0; cout_kill = 1'b0;

    // Reset and release sequence.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dp_rst", 32'(f4_dp_rst), 32'd1);
    check("rst_in_ready", 32'(f4_in_ready), 32'd0);
    check("rst_out_valid", 32'(f4_out_valid), 32'd0);
    check("rst_outs", 32'({f4_out_sum, f4_out_cout, f4_out_err}), 32'd0);
    check("rst_rails", 32'({f4_dr_a, f4_dr_b, f4_dr_cin}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel1_dp_rst", 32'(f4_dp_rst), 32'd1);
    check("rel1_in_ready", 32'(f4_in_ready), 32'd0);
    @(posedge clk); #1;
    check("rel2_dp_rst", 32'(f4_dp_rst), 32'd0);
    check("rel2_in_ready", 32'(f4_in_ready), 32'd0);
    @(posedge clk); #1;
    check("rel3_in_ready", 32'(f4_in_ready), 32'd1);
    check("rel3_rails", 32'({f4_dr_a, f4_dr_b, f4_dr_cin}), 32'd0);

    // First TP operation on WIDTH=1: rail toggles and N+4 latency.
    do_op(SEL_TP1, 4'h1, 4'h0, 1'b0, lat);
    check("tp1_lat", 32'(lat), 32'd4);
    check("tp1_sum", 32'(t1_out_sum), 32'd1);
    check("tp1_cout", 32'(t1_out_cout), 32'd0);
    check("tp1_err", 32'(t1_out_err), 32'd0);
    check("tp1_dr_a", 32'(t1_dr_a), 32'h2);
    check("tp1_dr_b", 32'(t1_dr_b), 32'h1);
    check("tp1_dr_cin", 32'(t1_dr_cin), 32'h1);
    consume();

    // Table-driven operations.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_sum", i), 32'(cur_sum), 32'(vecs[i].sum));
      check($sformatf("v%0d_cout", i), 32'(cur_cout), 32'(vecs[i].cout));
      check($sformatf("v%0d_err", i), 32'(cur_err), 32'd0);
      if (vecs[i].sel == SEL_FP4)
        check($sformatf("v%0d_spacer", i), 32'({f4_dr_a, f4_dr_b, f4_dr_cin}), 32'd0);
      consume();
    end

    // Backpressure on FP: result held, offered operands ignored.
    do_op(SEL_FP4, 4'h3, 4'h4, 1'b0, lat);
    check("bp_lat", 32'(lat), 32'd8);
    a_drv = 4'h9; b_drv = 4'h9; valid_drv = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!f4_out_valid || f4_out_sum !== 4'h7 || f4_out_cout !== 1'b0 ||
          f4_out_err !== 1'b0 || f4_in_ready !== 1'b0) bad++;
    end
    check("bp_stable_cycles", 32'(bad), 32'd0);
    // HOLD->IDLE edge with in_valid high must not accept.
    a_drv = 4'h6; b_drv = 4'h6; cin_drv = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_consumed", 32'(f4_out_valid), 32'd0);
    check("bp_no_accept", 32'(f4_in_ready), 32'd1);
    do_op(SEL_FP4, 4'h6, 4'h6, 1'b1, lat);
    check("bp_next_lat", 32'(lat), 32'd8);
    check("bp_next_sum", 32'({f4_out_cout, f4_out_sum}), 32'h0D);
    consume();

    // Timeout: carry-out rails never complete.
    cout_kill = 1'b1;
    do_op(SEL_FP4, 4'h1, 4'h1, 1'b1, lat);
    check("tmo_lat", 32'(lat), 32'd16);
    check("tmo_err", 32'(f4_out_err), 32'd1);
    check("tmo_result", 32'({f4_out_cout, f4_out_sum}), 32'd0);
    check("tmo_spacer", 32'({f4_dr_a, f4_dr_b, f4_dr_cin}), 32'd0);
    consume();
    cout_kill = 1'b0;
    do_op(SEL_FP4, 4'h1, 4'h1, 1'b1, lat);
    check("post_tmo_lat", 32'(lat), 32'd8);
    check("post_tmo_result", 32'({f4_out_cout, f4_out_sum}), 32'h03);
    check("post_tmo_err", 32'(f4_out_err), 32'd0);
    consume();

    // Reset in the middle of a TP operation.
    accept_only(SEL_TP4, 4'h2, 4'h3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dp_rst", 32'(t4_dp_rst), 32'd1);
    check("mid_rst_rails", 32'({t4_dr_a, t4_dr_b, t4_dr_cin}), 32'd0);
    check("mid_rst_ref", 32'(u_tp4.ref_q), 32'd0);
    check("mid_rst_out_valid", 32'(t4_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (t4_out_valid) bad++;
    end
    check("mid_rst_no_result", 32'(bad), 32'd0);
    do_op(SEL_TP4, 4'h2, 4'h3, 1'b0, lat);
    check("mid_rst_next_lat", 32'(lat), 32'd4);
    check("mid_rst_next_result", 32'({t4_out_cout, t4_out_sum}), 32'h05);
    check("mid_rst_next_err", 32'(t4_out_err), 32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
